thermal_frame_modulator: RTL
============================

Name: thermal_frame_modulator

Overview:
- Upstream stage of the thermal covert-channel transmitter.
- Accepts bytes over a valid/ready handshake and frames each one: alternating preamble, start bit, 8 data bits MSB first, optional parity, then a cool-down guard.
- Output heater_enable drives the enable input of the ring-oscillator heater/counter stage: a 1 symbol means heat, a 0 symbol means idle.
- Each symbol is held for a fixed number of clock cycles.

Parameters:
- BIT_CYCLES, 50000000: clock cycles per symbol (1 s at 50 MHz). Must be >= 1.
- PREAMBLE_BITS, 4: preamble length. Pattern alternates starting with 1 (1,0,1,0,...). Must be >= 1.
- GUARD_CYCLES, 100000000: cycles of forced heater_enable=0 after each frame. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a byte
- heater_enable  out  1  registered symbol level to the heater stage
- busy  out  1  frame in progress, guard included
- frame_done  out  1  one-cycle pulse when the guard period ends

Behaviour:
- Reset values: tx_ready=1, heater_enable=0, busy=0, frame_done=0, state=IDLE, all counters 0.
- Reset is synchronous. Asserting it mid-frame aborts the frame; on the next edge all outputs take their reset values. The aborted byte is discarded.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid && tx_ready. tx_data is latched into an internal shift register on that edge.
  - tx_ready=1 only in IDLE. tx_valid while not ready is ignored; no queueing.
- States: IDLE -> PREAMBLE -> START -> DATA -> (PARITY) -> GUARD -> IDLE.
- IDLE: heater_enable=0, busy=0. On transfer, go to PREAMBLE. On the same edge, heater_enable<=1, busy<=1, tx_ready<=0.
- Symbol timing:
  - A cycle counter runs 0..BIT_CYCLES-1 per symbol.
  - At terminal count it wraps to 0 and the next symbol level is registered onto heater_enable on that same edge.
  - Every symbol is therefore exactly BIT_CYCLES cycles wide. With BIT_CYCLES=1 a new symbol appears every cycle.
- PREAMBLE: symbol k (0-based) = ~k[0]. Runs PREAMBLE_BITS symbols, then START.
- START: one symbol of level 1.
- DATA: 8 symbols, tx_data[7] first. Bit index counts 7 down to 0.
- PARITY: present only when the optional feature is compiled in.
- GUARD:
  - heater_enable=0 for GUARD_CYCLES cycles.
  - On the final guard cycle's edge: frame_done<=1 for one cycle, state<=IDLE, tx_ready<=1, busy<=0.
  - A new byte can be accepted on the cycle after frame_done.
- Latency: first heater_enable=1 appears 1 cycle after the accepting edge.
- Total frame cycles, accept edge to frame_done edge: (PREAMBLE_BITS+9[+1])*BIT_CYCLES + GUARD_CYCLES.
- Counter widths are $clog2 of the relevant parameter, minimum 1 bit. No overflow is possible within legal parameters.

Optional Feature:
- Macro: THERMAL_PARITY_EN.
- Defined: a PARITY state follows DATA. It emits one symbol equal to the even parity (XOR) of the latched byte, then enters GUARD.
- Undefined: DATA goes directly to GUARD. No parity logic is synthesised.

Decomposition:
- Package thermal_pkg:
  - state enum typedef (IDLE, PREAMBLE, START, DATA, PARITY, GUARD)
  - START_LEVEL=1'b1
  - DATA_BITS=8
- Sub-module thermal_symbol_timer: BIT_CYCLES counter with load/clear input and a terminal-count pulse output. The GUARD phase reuses it via a separate terminal value.

Test Plan (BIT_CYCLES=4, PREAMBLE_BITS=4, GUARD_CYCLES=8):
- Send 0xA5, parity off -> heater_enable, 4 cycles per symbol: 1,0,1,0,1,1,0,1,0,0,1,0,1, then 0 for 8 cycles. frame_done pulses exactly 60 cycles after the accepting edge.
- Send 0x00 -> data symbols all 0; only preamble and start levels are high. tx_ready stays 0 throughout busy.
- Hold tx_valid=1 with 0xFF then 0x01 continuously -> second byte is accepted exactly 1 cycle after the frame_done pulse. The back-to-back frames match the expected pattern.
- Assert reset for 1 cycle during DATA bit 3 -> next edge: heater_enable=0, tx_ready=1, busy=0. A following 0x3C frames correctly from the preamble.
- BIT_CYCLES=1, send 0x81 -> one symbol per cycle, pattern 1,0,1,0,1,1,0,0,0,0,0,0,1.
- THERMAL_PARITY_EN defined, send 0x07 -> parity symbol 1. Send 0x03 -> parity symbol 0. frame_done arrives 64 cycles after the accepting edge.

Source files
------------

// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal covert-channel frame modulator.
// Contents: FSM state enum, start-bit level, data width and a counter-width
// helper used to size the symbol/guard/preamble counters.
package thermal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        PARITY,
        GUARD
    } state_t;

    localparam logic        START_LEVEL = 1'b1;
    localparam int unsigned DATA_BITS   = 8;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/thermal_symbol_timer.sv
// Free-running cycle counter used to time symbols and the guard period.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset (count -> 0)
//   clear_i  hold the count at 0
//   term_i   terminal count value (period - 1)
//   tc_o     high on the cycle the count equals term_i; the count wraps
//            to 0 on that edge
module thermal_symbol_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign tc_o = (count_q == term_i);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || tc_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/thermal_frame_modulator.sv
// Frames bytes for the thermal covert channel: alternating preamble
// (starting with 1), a start bit, 8 data bits MSB first, an optional even
// parity bit, then a cool-down guard with the heater held off. Each symbol
// lasts BIT_CYCLES clocks; heater_enable carries the registered symbol level.
// Optional feature: define THERMAL_PARITY_EN to insert the parity symbol.
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset, aborts any frame
//   tx_data        byte to transmit
//   tx_valid       tx_data valid
//   tx_ready       high only in IDLE; transfer on tx_valid && tx_ready
//   heater_enable  registered symbol level to the heater stage
//   busy           frame in progress, guard included
//   frame_done     one-cycle pulse when the guard period ends
module thermal_frame_modulator
    import thermal_pkg::*;
#(
    parameter int unsigned BIT_CYCLES    = 50000000,
    parameter int unsigned PREAMBLE_BITS = 4,
    parameter int unsigned GUARD_CYCLES  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       heater_enable,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BW = cnt_width(BIT_CYCLES);
    localparam int unsigned GW = cnt_width(GUARD_CYCLES);
    localparam int unsigned TW = (BW > GW) ? BW : GW;
    localparam int unsigned PW = cnt_width(PREAMBLE_BITS);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_TERM   = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] GUARD_TERM = TW'(GUARD_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PREAMBLE_BITS - 1);

    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [PW-1:0]        pre_idx_q;
    logic [IW-1:0]        bit_idx_q;
    logic                 tx_ready_q;
    logic                 heater_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef THERMAL_PARITY_EN
    logic                 parity_q;
`endif

    logic          tc;
    logic [TW-1:0] term;

    // The guard period shares the symbol timer with its own terminal value.
    assign term = (state_q == GUARD) ? GUARD_TERM : BIT_TERM;

    thermal_symbol_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk_i  (clk),
        .reset_i(reset),
        .clear_i(state_q == IDLE),
        .term_i (term),
        .tc_o   (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            pre_idx_q  <= '0;
            bit_idx_q  <= '0;
            tx_ready_q <= 1'b1;
            heater_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef THERMAL_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q    <= PREAMBLE;
                        shift_q    <= tx_data;
                        pre_idx_q  <= '0;
                        heater_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
`ifdef THERMAL_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                    end
                end
                PREAMBLE: begin
                    if (tc) begin
                        if (pre_idx_q == PRE_LAST) begin
                            state_q  <= START;
                            heater_q <= START_LEVEL;
                        end else begin
                            pre_idx_q <= pre_idx_q + 1'b1;
                            // Next symbol k+1 has level ~(k+1)[0], i.e. k[0].
                            heater_q  <= pre_idx_q[0];
                        end
                    end
                end
                START: begin
                    if (tc) begin
                        state_q   <= DATA;
                        bit_idx_q <= '1;
                        heater_q  <= shift_q[DATA_BITS-1];
                        shift_q   <= {shift_q[DATA_BITS-2:0], 1'b0};
                    end
                end
                DATA: begin
                    if (tc) begin
                        if (bit_idx_q == '0) begin
`ifdef THERMAL_PARITY_EN
                            state_q  <= PARITY;
                            heater_q <= parity_q;
`else
                            state_q  <= GUARD;
                            heater_q <= 1'b0;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q - 1'b1;
                            heater_q  <= shift_q[DATA_BITS-1];
                            shift_q   <= {shift_q[DATA_BITS-2:0], 1'b0};
                        end
                    end
                end
`ifdef THERMAL_PARITY_EN
                PARITY: begin
                    if (tc) begin
                        state_q  <= GUARD;
                        heater_q <= 1'b0;
                    end
                end
`endif
                GUARD: begin
                    if (tc) begin
                        state_q    <= IDLE;
                        done_q     <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_ready_q <= 1'b1;
                    heater_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready      = tx_ready_q;
    assign heater_enable = heater_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule
